// File: rtl/x86_pkg.sv
// Shared types for the x86 effective-address decoder.
// Holds state encodings, segment ids and the 16-bit rm base/index tables.
package x86_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MODRM = 3'd1,
        ST_SIB   = 3'd2,
        ST_DISP  = 3'd3,
        ST_CALC  = 3'd4
    } ea_state_e;

    localparam logic [2:0] SEG_ES = 3'd0;
    localparam logic [2:0] SEG_CS = 3'd1;
    localparam logic [2:0] SEG_SS = 3'd2;
    localparam logic [2:0] SEG_DS = 3'd3;
    localparam logic [2:0] SEG_FS = 3'd4;
    localparam logic [2:0] SEG_GS = 3'd5;

    localparam logic [2:0] REG_BX = 3'd3;
    localparam logic [2:0] REG_SP = 3'd4;
    localparam logic [2:0] REG_BP = 3'd5;
    localparam logic [2:0] REG_SI = 3'd6;
    localparam logic [2:0] REG_DI = 3'd7;

    // rm 4/5 use si/di as the lone base term so they share the base read port
    function automatic logic [2:0] rm16_base(input logic [2:0] rm);
        logic [2:0] r;
        case (rm)
            3'd0, 3'd1, 3'd7: r = REG_BX;
            3'd2, 3'd3, 3'd6: r = REG_BP;
            3'd4:             r = REG_SI;
            default:          r = REG_DI;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] rm16_index(input logic [2:0] rm);
        return rm[0] ? REG_DI : REG_SI;
    endfunction

endpackage

// File: rtl/x86_ea_calc.sv
// Effective-address adder: base + scaled index + displacement.
// 16-bit mode wraps the sum at 2^16 and zero-extends it.
module x86_ea_calc #(
    parameter int EA_W = 32
) (
    input  logic            mode32_i,
    input  logic            base_en_i,
    input  logic [31:0]     base_val_i,
    input  logic            index_en_i,
    input  logic [31:0]     index_val_i,
    input  logic [1:0]      scale_i,
    input  logic [31:0]     disp_i,
    output logic [EA_W-1:0] ea_o
);

    logic [31:0] base_t;
    logic [31:0] index_t;
    logic [31:0] sum;
    logic [31:0] full;

    always_comb begin
        base_t  = base_en_i ? base_val_i : 32'd0;
        index_t = index_en_i ? (index_val_i << scale_i) : 32'd0;
        sum     = base_t + index_t + disp_i;
        full    = mode32_i ? sum : {16'd0, sum[15:0]};
    end

    assign ea_o = full[EA_W-1:0];

endmodule

// File: rtl/x86_ea_decoder.sv
// ModRM/SIB/displacement decoder, one instruction byte per enabled cycle.
// Produces reg/rm fields, memory form, effective address and segment.
module x86_ea_decoder
    import x86_pkg::*;
#(
    parameter bit ADDR32_EN = 1'b1,
    parameter int EA_W      = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            locked,
    input  logic            start,
    input  logic            adsize,
    input  logic            seg_ovr,
    input  logic [2:0]      seg_ovr_id,
    input  logic [7:0]      i_data,
    output logic            byte_take,
    output logic [2:0]      rd_base_id,
    output logic [2:0]      rd_index_id,
    input  logic [31:0]     base_val,
    input  logic [31:0]     index_val,
    output logic [2:0]      reg_field,
    output logic [2:0]      rm_field,
    output logic            is_mem,
    output logic [EA_W-1:0] ea,
    output logic [2:0]      seg_id,
    output logic            busy,
    output logic            done
);

    ea_state_e       state_q, state_d;
    logic            adsize_q, ovr_q, is_mem_q;
    logic [2:0]      ovr_id_q, rd_base_q, rd_index_q, seg_q;
    logic [7:0]      modrm_q;
    logic [31:0]     disp_q, disp_ext;
    logic [2:0]      dlen_q, dcnt_q;
    logic            base_en_q, index_en_q, ss_q;
    logic [1:0]      scale_q;
    logic [EA_W-1:0] ea_q, calc_ea;
    logic [2:0]      calc_seg;

    logic       mode32, m_sib, s_nobase;
    logic [1:0] mod_i, mod_q;
    logic [2:0] rm_i, m_len, s_len;

    assign mode32 = ADDR32_EN && adsize_q;
    assign mod_i  = i_data[7:6];
    assign rm_i   = i_data[2:0];
    assign mod_q  = modrm_q[7:6];

    always_comb begin
        m_len = 3'd0;
        case (mod_i)
            2'b01: m_len = 3'd1;
            2'b10: m_len = mode32 ? 3'd4 : 3'd2;
            2'b00: begin
                if (mode32 && rm_i == 3'd5)
                    m_len = 3'd4;
                else if (!mode32 && rm_i == 3'd6)
                    m_len = 3'd2;
            end
            default: m_len = 3'd0;
        endcase
        m_sib    = mode32 && mod_i != 2'b11 && rm_i == REG_SP;
        s_nobase = i_data[2:0] == REG_BP && mod_q == 2'b00;
        case (mod_q)
            2'b01:   s_len = 3'd1;
            2'b10:   s_len = 3'd4;
            default: s_len = s_nobase ? 3'd4 : 3'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else if (locked)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_MODRM;
            ST_MODRM: begin
                if (mod_i == 2'b11)
                    state_d = ST_CALC;
                else if (m_sib)
                    state_d = ST_SIB;
                else if (m_len != 3'd0)
                    state_d = ST_DISP;
                else
                    state_d = ST_CALC;
            end
            ST_SIB:   state_d = (s_len != 3'd0) ? ST_DISP : ST_CALC;
            ST_DISP:  if (dcnt_q == dlen_q - 3'd1) state_d = ST_CALC;
            ST_CALC:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            adsize_q   <= 1'b0;
            ovr_q      <= 1'b0;
            ovr_id_q   <= 3'd0;
            modrm_q    <= 8'd0;
            is_mem_q   <= 1'b0;
            disp_q     <= 32'd0;
            dlen_q     <= 3'd0;
            dcnt_q     <= 3'd0;
            rd_base_q  <= 3'd0;
            rd_index_q <= 3'd0;
            base_en_q  <= 1'b0;
            index_en_q <= 1'b0;
            scale_q    <= 2'd0;
            ss_q       <= 1'b0;
            ea_q       <= '0;
            seg_q      <= SEG_DS;
        end else if (locked) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        adsize_q <= adsize;
                        ovr_q    <= seg_ovr;
                        ovr_id_q <= seg_ovr_id;
                    end
                end
                ST_MODRM: begin
                    modrm_q  <= i_data;
                    is_mem_q <= mod_i != 2'b11;
                    disp_q   <= 32'd0;
                    dcnt_q   <= 3'd0;
                    dlen_q   <= m_len;
                    scale_q  <= 2'd0;
                    if (mode32) begin
                        rd_base_q  <= rm_i;
                        rd_index_q <= 3'd0;
                        index_en_q <= 1'b0;
                        base_en_q  <= !(mod_i == 2'b00 && rm_i == REG_BP);
                        ss_q       <= rm_i == REG_BP && mod_i != 2'b00;
                    end else begin
                        rd_base_q  <= rm16_base(rm_i);
                        rd_index_q <= rm16_index(rm_i);
                        index_en_q <= !rm_i[2];
                        base_en_q  <= !(mod_i == 2'b00 && rm_i == 3'd6);
                        ss_q       <= rm16_base(rm_i) == REG_BP &&
                                      !(mod_i == 2'b00 && rm_i == 3'd6);
                    end
                end
                ST_SIB: begin
                    rd_base_q  <= i_data[2:0];
                    rd_index_q <= i_data[5:3];
                    index_en_q <= i_data[5:3] != REG_SP;
                    scale_q    <= i_data[7:6];
                    base_en_q  <= !s_nobase;
                    ss_q       <= !s_nobase &&
                                  (i_data[2:0] == REG_SP || i_data[2:0] == REG_BP);
                    dlen_q     <= s_len;
                end
                ST_DISP: begin
                    disp_q[{dcnt_q[1:0], 3'b000} +: 8] <= i_data;
                    dcnt_q <= dcnt_q + 3'd1;
                end
                ST_CALC: begin
                    ea_q  <= calc_ea;
                    seg_q <= calc_seg;
                end
                default: ;
            endcase
        end
    end

    assign disp_ext = (dlen_q == 3'd1) ? {{24{disp_q[7]}}, disp_q[7:0]} : disp_q;
    assign calc_seg = ovr_q ? ovr_id_q : (ss_q ? SEG_SS : SEG_DS);

    x86_ea_calc #(.EA_W(EA_W)) u_calc (
        .mode32_i    (mode32),
        .base_en_i   (base_en_q),
        .base_val_i  (base_val),
        .index_en_i  (index_en_q),
        .index_val_i (index_val),
        .scale_i     (scale_q),
        .disp_i      (disp_ext),
        .ea_o        (calc_ea)
    );

    // ea/seg_id follow the adder while done is high, then hold the captured copy
    always_comb begin
        byte_take = 1'b0;
        unique case (1'b1)
            state_q == ST_MODRM,
            state_q == ST_SIB,
            state_q == ST_DISP: byte_take = 1'b1;
            default:            byte_take = 1'b0;
        endcase
        busy   = state_q != ST_IDLE;
        done   = state_q == ST_CALC;
        ea     = (state_q == ST_CALC) ? calc_ea : ea_q;
        seg_id = (state_q == ST_CALC) ? calc_seg : seg_q;
    end

    assign rd_base_id  = rd_base_q;
    assign rd_index_id = rd_index_q;
    assign reg_field   = modrm_q[5:3];
    assign rm_field    = modrm_q[2:0];
    assign is_mem      = is_mem_q;

endmodule

// File: tb/tb_x86_ea_decoder.sv
// Randomised bench for x86_ea_decoder against an addressing-mode model.
// A fetch model feeds bytes and advances on each enabled byte_take.
module tb_x86_ea_decoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        locked = 1'b0;
    logic        start = 1'b0;
    logic        adsize = 1'b0;
    logic        seg_ovr = 1'b0;
    logic [2:0]  seg_ovr_id = 3'd0;
    logic [7:0]  i_data = 8'd0;
    logic        byte_take;
    logic [2:0]  rd_base_id, rd_index_id;
    logic [31:0] base_val, index_val;
    logic [2:0]  reg_field, rm_field;
    logic        is_mem;
    logic [31:0] ea;
    logic [2:0]  seg_id;
    logic        busy, done;

    logic [31:0] regs [8];
    logic [7:0]  stream [8];

    int total = 0;
    int bad = 0;

    x86_ea_decoder #(.ADDR32_EN(1'b1), .EA_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .start       (start),
        .adsize      (adsize),
        .seg_ovr     (seg_ovr),
        .seg_ovr_id  (seg_ovr_id),
        .i_data      (i_data),
        .byte_take   (byte_take),
        .rd_base_id  (rd_base_id),
        .rd_index_id (rd_index_id),
        .base_val    (base_val),
        .index_val   (index_val),
        .reg_field   (reg_field),
        .rm_field    (rm_field),
        .is_mem      (is_mem),
        .ea          (ea),
        .seg_id      (seg_id),
        .busy        (busy),
        .done        (done)
    );

    assign base_val  = regs[rd_base_id];
    assign index_val = regs[rd_index_id];

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Address arithmetic straight from the addressing-mode rules
    function automatic void model(input bit m32, input bit ovr, input logic [2:0] oid,
                                  output logic [31:0] e_ea, output logic [2:0] e_seg,
                                  output int e_bytes, output bit e_mem);
        logic [7:0]  m0, sb;
        logic [1:0]  md;
        logic [2:0]  rm, breg;
        logic [31:0] t, d, idx;
        int          dl, pos;
        bit          nobase, use_ss;
        m0 = stream[0];
        md = m0[7:6];
        rm = m0[2:0];
        e_mem = (md != 2'b11);
        d = 0;
        t = 0;
        use_ss = 0;
        if (!e_mem) begin
            e_bytes = 1;
            e_ea = 0;
        end else if (!m32) begin
            dl = (md == 1) ? 1 : (md == 2) ? 2 : (rm == 6) ? 2 : 0;
            if (dl == 1) d = {{24{stream[1][7]}}, stream[1]};
            if (dl == 2) d = {16'd0, stream[2], stream[1]};
            case (rm)
                0: t = regs[3] + regs[6];
                1: t = regs[3] + regs[7];
                2: t = regs[5] + regs[6];
                3: t = regs[5] + regs[7];
                4: t = regs[6];
                5: t = regs[7];
                6: t = (md == 0) ? 0 : regs[5];
                default: t = regs[3];
            endcase
            use_ss = (rm == 2) || (rm == 3) || (rm == 6 && md != 0);
            e_ea = (t + d) & 32'h0000_FFFF;
            e_bytes = 1 + dl;
        end else begin
            idx = 0;
            if (rm == 4) begin
                sb = stream[1];
                pos = 2;
                breg = sb[2:0];
                nobase = (breg == 5) && (md == 0);
                if (sb[5:3] != 4) idx = regs[sb[5:3]] * (32'd1 << sb[7:6]);
            end else begin
                pos = 1;
                breg = rm;
                nobase = (md == 0) && (rm == 5);
            end
            dl = (md == 1) ? 1 : (md == 2) ? 4 : nobase ? 4 : 0;
            for (int k = 0; k < dl; k++) d = d | (32'(stream[pos + k]) << (8 * k));
            if (dl == 1) d = {{24{d[7]}}, d[7:0]};
            e_ea = (nobase ? 32'd0 : regs[breg]) + idx + d;
            use_ss = !nobase && (breg == 4 || breg == 5);
            e_bytes = pos + dl;
        end
        e_seg = ovr ? oid : (use_ss ? 3'd2 : 3'd3);
    endfunction

    task automatic run_case(input string nm, input bit m32, input bit ovr,
                            input logic [2:0] oid, input int lock_at);
        logic [31:0] e_ea, ea_seen;
        logic [2:0]  e_seg, seg_seen;
        logic [7:0]  m0;
        int          e_bytes, en, wall, takes, ptr, lock_left;
        bit          e_mem, got, bt, used;
        model(m32, ovr, oid, e_ea, e_seg, e_bytes, e_mem);
        m0 = stream[0];
        @(negedge clock);
        adsize = m32;
        seg_ovr = ovr;
        seg_ovr_id = oid;
        start = 1'b1;
        locked = 1'b1;
        i_data = stream[0];
        @(negedge clock);
        adsize = 1'($urandom_range(0, 1));
        seg_ovr = 1'($urandom_range(0, 1));
        seg_ovr_id = 3'($urandom_range(0, 7));
        en = 1;
        wall = 0;
        takes = 0;
        ptr = 0;
        got = 0;
        used = 0;
        lock_left = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (lock_at != 0 && en == lock_at && !used) begin
                lock_left = 3;
                used = 1;
            end
            locked = (lock_left == 0);
            if (lock_left > 0) lock_left--;
            start = 1'($urandom_range(0, 1));
            bt = byte_take;
            i_data = (ptr < 8) ? stream[ptr] : 8'hCC;
            @(posedge clock);
            wall++;
            if (locked) begin
                en++;
                if (bt) begin
                    ptr++;
                    takes++;
                end
            end
            @(negedge clock);
        end
        chk({nm, "/done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, "/latency"}, en, e_bytes + 1);
            chk({nm, "/wall"}, wall, en - 1 + (used ? 3 : 0));
            chk({nm, "/takes"}, takes, e_bytes);
            chk({nm, "/is_mem"}, 32'(is_mem), 32'(e_mem));
            chk({nm, "/reg"}, 32'(reg_field), 32'(m0[5:3]));
            chk({nm, "/rm"}, 32'(rm_field), 32'(m0[2:0]));
            if (e_mem) begin
                chk({nm, "/ea"}, ea, e_ea);
                chk({nm, "/seg"}, 32'(seg_id), 32'(e_seg));
            end
            ea_seen = ea;
            seg_seen = seg_id;
            locked = 1'b0;
            start = 1'b0;
            repeat (2) @(negedge clock);
            chk({nm, "/hold_done"}, 32'(done), 32'd1);
            chk({nm, "/hold_ea"}, ea, ea_seen);
            locked = 1'b1;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            chk({nm, "/exit_busy"}, {31'd0, busy, done}, 32'd0);
            chk({nm, "/kept_ea"}, ea, ea_seen);
            chk({nm, "/kept_seg"}, 32'(seg_id), 32'(seg_seen));
        end
        start = 1'b0;
        locked = 1'b1;
    endtask

    initial begin
        bit rst_done;
        for (int i = 0; i < 8; i++) begin
            regs[i] = 32'd0;
            stream[i] = 8'd0;
        end
        #12;
        chk("rst_ctl", {28'd0, busy, done, byte_take, is_mem}, 32'd0);
        chk("rst_ea", ea, 32'd0);
        chk("rst_seg", 32'(seg_id), 32'd3);
        chk("rst_fields", {20'd0, reg_field, rm_field, rd_base_id, rd_index_id}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        locked = 1'b1;
        repeat (2) @(negedge clock);

        regs[3] = 32'h1000;
        regs[6] = 32'h0020;
        stream[0] = 8'h40;
        stream[1] = 8'hFE;
        run_case("t1", 0, 0, 3'd0, 0);
        chk("t1_ea_const", ea, 32'h0000_101E);
        chk("t1_seg_const", 32'(seg_id), 32'd3);

        stream[0] = 8'h06;
        stream[1] = 8'h34;
        stream[2] = 8'h12;
        run_case("t2", 0, 0, 3'd0, 0);
        chk("t2_ea_const", ea, 32'h0000_1234);

        regs[5] = 32'h0000_0200;
        stream[0] = 8'h46;
        stream[1] = 8'h00;
        run_case("t3", 0, 0, 3'd0, 0);
        chk("t3_ea_const", ea, 32'h0000_0200);
        chk("t3_seg_ss", 32'(seg_id), 32'd2);
        run_case("t3o", 0, 1, 3'd0, 0);
        chk("t3o_seg_es", 32'(seg_id), 32'd0);

        regs[0] = 32'h100;
        regs[1] = 32'h10;
        stream[0] = 8'h04;
        stream[1] = 8'h88;
        run_case("t4", 1, 0, 3'd0, 0);
        chk("t4_ea_const", ea, 32'h0000_0140);

        stream[0] = 8'hC3;
        run_case("t5", 0, 0, 3'd0, 1);
        chk("t5_fields", {24'd0, is_mem, reg_field, rm_field}, 32'h03);

        stream[0] = 8'h86;
        stream[1] = 8'h34;
        stream[2] = 8'h12;
        @(negedge clock);
        adsize = 1'b0;
        seg_ovr = 1'b0;
        start = 1'b1;
        i_data = stream[0];
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        i_data = stream[1];
        chk("t6_in_disp", {30'd0, busy, byte_take}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {29'd0, busy, done, byte_take}, 32'd0);
        chk("t6_rst_seg", 32'(seg_id), 32'd3);
        rst_done = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) rst_done = 1;
        end
        chk("t6_no_done", 32'(rst_done), 32'd0);
        reset_n = 1'b1;
        regs[3] = 32'h0000_4000;
        regs[6] = 32'h0000_0011;
        stream[0] = 8'h80;
        stream[1] = 8'h01;
        stream[2] = 8'h10;
        run_case("t6_after", 0, 0, 3'd0, 0);
        chk("t6_ea_const", ea, 32'h0000_5012);

        for (int n = 0; n < 60; n++) begin
            bit         m32, ovr;
            logic [2:0] oid;
            int         la;
            for (int i = 0; i < 8; i++) begin
                regs[i] = $urandom;
                stream[i] = 8'($urandom_range(0, 255));
            end
            m32 = 1'($urandom_range(0, 1));
            ovr = ($urandom_range(0, 3) == 0);
            oid = 3'($urandom_range(0, 5));
            la = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_case("rnd", m32, ovr, oid, la);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
